// File: rtl/tb_hostmem_axi_rd_resp.sv
// AXI4 read-slave host-memory model: in-order INCR bursts after a
// fixed latency, SLVERR for out-of-range beats, backdoor write port.
module tb_hostmem_axi_rd_resp #(
  parameter int DATA_W  = 512,
  parameter int ID_W    = 16,
  parameter int MEM_AW  = 12,
  parameter int RD_LAT  = 4,
  parameter int MAX_OUT = 8
) (
  input  logic              clk_main_a0,
  input  logic              rst_main_n,
  input  logic [ID_W-1:0]   arid,
  input  logic [63:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              bd_wr_en,
  input  logic [MEM_AW-1:0] bd_wr_addr,
  input  logic [DATA_W-1:0] bd_wr_data
);

  localparam int OFFS  = $clog2(DATA_W / 8);
  localparam int PG_SH = 12 - OFFS;
  localparam int PW    = $clog2(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  logic [DATA_W-1:0] r_mem [2**MEM_AW];

  logic [ID_W-1:0]   r_q_id    [MAX_OUT];
  logic [63:0]       r_q_addr  [MAX_OUT];
  logic [7:0]        r_q_len   [MAX_OUT];
  logic [15:0]       r_q_stamp [MAX_OUT];

  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [PW:0]       r_count;
  logic [15:0]       r_cnt;
  state_t            r_state;
  logic [7:0]        r_beat;
  logic              r_arready;
  logic              r_rvalid;
  logic              r_rlast;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;

  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_last_acc;
  logic [PW-1:0]     w_nxt_rp;
  logic [15:0]       w_head_age;
  logic [15:0]       w_next_age;
  logic              w_head_elig;
  logic              w_next_elig;
  logic [PW:0]       w_count_nxt;
  logic              w_ld_go;
  logic [PW-1:0]     w_ld_ptr;
  logic [7:0]        w_ld_k;
  logic [63:0]       w_base;
  logic [63:0]       w_wa;
  logic [63:0]       w_end;
  logic              w_cross;
  logic              w_end_ok;
  logic              w_beat_ok;
  logic              w_err;
  logic [DATA_W-1:0] w_rd;

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  assign w_push      = arvalid && r_arready;
  assign w_accept    = r_rvalid && rready;
  assign w_last_acc  = w_accept && (r_beat == r_q_len[r_rp]);
  assign w_pop       = w_last_acc;
  assign w_nxt_rp    = r_rp + 1'b1;
  assign w_head_age  = r_cnt - r_q_stamp[r_rp];
  assign w_next_age  = r_cnt - r_q_stamp[w_nxt_rp];
  assign w_head_elig = w_head_age >= 16'(RD_LAT);
  assign w_next_elig = w_next_age >= 16'(RD_LAT);
  assign w_count_nxt = r_count + (PW+1)'(w_push)
                     - (PW+1)'(w_pop);

  // Pick which queue entry and beat index to load this cycle
  always_comb begin
    w_ld_go  = 1'b0;
    w_ld_ptr = r_rp;
    w_ld_k   = 8'd0;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (r_count != '0 && w_head_elig) w_ld_go = 1'b1;
      end
      S_BURST: begin
        if (w_last_acc) begin
          if (r_count >= (PW+1)'(2) && w_next_elig) begin
            w_ld_go  = 1'b1;
            w_ld_ptr = w_nxt_rp;
          end
        end else if (w_accept) begin
          w_ld_go = 1'b1;
          w_ld_k  = r_beat + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // A burst leaving memory is judged per beat; an in-memory
  // 4KB crossing poisons the whole burst.
  assign w_base    = r_q_addr[w_ld_ptr] >> OFFS;
  assign w_wa      = w_base + 64'(w_ld_k);
  assign w_end     = w_base + 64'(r_q_len[w_ld_ptr]);
  assign w_cross   = (w_base >> PG_SH) != (w_end >> PG_SH);
  assign w_end_ok  = (w_end >> MEM_AW) == 64'd0;
  assign w_beat_ok = (w_wa >> MEM_AW) == 64'd0;
  assign w_err     = !w_beat_ok || (w_cross && w_end_ok);
  assign w_rd      = r_mem[w_wa[MEM_AW-1:0]];

  // Backdoor write; beat loads on the same edge see old data
  always_ff @(posedge clk_main_a0) begin
    if (bd_wr_en) r_mem[bd_wr_addr] <= bd_wr_data;
  end

  // Command queue payload; no reset needed, pointers qualify it
  always_ff @(posedge clk_main_a0) begin
    if (w_push) begin
      r_q_id[r_wp]    <= arid;
      r_q_addr[r_wp]  <= araddr;
      r_q_len[r_wp]   <= arlen;
      r_q_stamp[r_wp] <= r_cnt;
    end
  end

  // Queue pointers, cycle counter and R-channel FSM
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_cnt     <= '0;
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
    end else begin
      r_cnt     <= r_cnt + 16'd1;
      r_count   <= w_count_nxt;
      r_arready <= w_count_nxt < (PW+1)'(MAX_OUT);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= w_nxt_rp;
      if (w_ld_go) begin
        r_state  <= S_BURST;
        r_rvalid <= 1'b1;
        r_beat   <= w_ld_k;
        r_rid    <= r_q_id[w_ld_ptr];
        r_rdata  <= w_err ? '0 : w_rd;
        r_rresp  <= w_err ? 2'b10 : 2'b00;
        r_rlast  <= w_ld_k == r_q_len[w_ld_ptr];
      end else if (w_accept) begin
        r_state  <= S_IDLE;
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end else if (r_state == S_IDLE && r_count != '0) begin
        r_state  <= S_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_tb_hostmem_axi_rd_resp.sv
// Directed bench for the AXI read-slave host-memory model.
// Each task drives one scenario and checks hand-derived values.
module tb_tb_hostmem_axi_rd_resp;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  arid = '0;
  logic [63:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [15:0]  rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready = 1'b0;
  logic         bd_wr_en = 1'b0;
  logic [11:0]  bd_wr_addr = '0;
  logic [511:0] bd_wr_data = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [511:0] c_data [16];
  logic [1:0]   c_resp [16];
  logic         c_last [16];
  logic [15:0]  c_id   [16];
  int           c_n;

  tb_hostmem_axi_rd_resp dut (
    .clk_main_a0 (clk),
    .rst_main_n  (rst_n),
    .arid        (arid),
    .araddr      (araddr),
    .arlen       (arlen),
    .arvalid     (arvalid),
    .arready     (arready),
    .rid         (rid),
    .rdata       (rdata),
    .rresp       (rresp),
    .rlast       (rlast),
    .rvalid      (rvalid),
    .rready      (rready),
    .bd_wr_en    (bd_wr_en),
    .bd_wr_addr  (bd_wr_addr),
    .bd_wr_data  (bd_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic bd_write(input int a, input logic [511:0] d);
    bd_wr_en = 1'b1;
    bd_wr_addr = 12'(a);
    bd_wr_data = d;
    cyc(1);
    bd_wr_en = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] id,
                         input logic [63:0] a,
                         input logic [7:0] l);
    int n;
    n = 0;
    arid = id;
    araddr = a;
    arlen = l;
    arvalid = 1'b1;
    while (!arready && n < 50) begin
      cyc(1);
      n++;
    end
    total_cnt++;
    if (arready !== 1'b1)
      $display("FAIL ar_timeout id=%h arready=%b want 1", id, arready);
    else pass_cnt++;
    cyc(1);
    arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    while (!rvalid && n < 30) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic collect(input int want);
    int n;
    n = 0;
    c_n = 0;
    rready = 1'b1;
    while (c_n < want && n < 100) begin
      if (rvalid) begin
        c_data[c_n] = rdata;
        c_resp[c_n] = rresp;
        c_last[c_n] = rlast;
        c_id[c_n] = rid;
        c_n++;
      end
      cyc(1);
      n++;
    end
    rready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    cyc(2);
    total_cnt++;
    if ({arready, rvalid, rlast, rresp, rid} !== '0 || rdata !== '0)
      $display("FAIL rst_outs ar=%b rv=%b rl=%b resp=%b id=%h want 0",
               arready, rvalid, rlast, rresp, rid);
    else pass_cnt++;
    rst_n = 1'b1;
    cyc(1);
    total_cnt++;
    if (arready !== 1'b1)
      $display("FAIL rst_arready got %b want 1", arready);
    else pass_cnt++;
    bd_write(5, {16{32'hA5A5_A5A5}});
    send_ar(16'h0011, 64'h140, 8'd0);
    wait_rvalid(n);
    total_cnt++;
    if (n !== 4) $display("FAIL t1_latency got %0d want 4", n);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== {16{32'hA5A5_A5A5}} || rresp !== 2'b00 ||
        rlast !== 1'b1 || rid !== 16'h0011)
      $display("FAIL t1_beat data=%h resp=%b last=%b id=%h want a5.. 0 1 0011",
               rdata[31:0], rresp, rlast, rid);
    else pass_cnt++;
    rready = 1'b1;
    cyc(1);
    rready = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b0) $display("FAIL t1_done rvalid=%b want 0", rvalid);
    else pass_cnt++;
  endtask

  task automatic test_stall_burst();
    int n;
    for (int i = 0; i < 4; i++) bd_write(i, pat(i));
    send_ar(16'h0022, 64'h0, 8'd3);
    wait_rvalid(n);
    total_cnt++;
    if (n !== 4) $display("FAIL t2_latency got %0d want 4", n);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      total_cnt++;
      if (rvalid !== 1'b1 || rdata !== pat(b) || rlast !== (b == 3))
        $display("FAIL t2_beat%0d rv=%b data=%h last=%b want 1 %h %b",
                 b, rvalid, rdata[31:0], rlast, pat(b) >> 480, b == 3);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (rvalid !== 1'b1 || rdata !== pat(b) || rlast !== (b == 3))
        $display("FAIL t2_hold%0d rv=%b data=%h last=%b want stable",
                 b, rvalid, rdata[31:0], rlast);
      else pass_cnt++;
      rready = 1'b1;
      cyc(1);
      rready = 1'b0;
    end
    total_cnt++;
    if (rvalid !== 1'b0) $display("FAIL t2_end rvalid=%b want 0", rvalid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    int got;
    logic hs;
    for (int i = 0; i < 9; i++) bd_write(i, pat(i + 100));
    for (int i = 0; i < 8; i++)
      send_ar(16'h0030 + 16'(i), 64'(i * 64), 8'd0);
    total_cnt++;
    if (arready !== 1'b0) $display("FAIL t3_full arready=%b want 0", arready);
    else pass_cnt++;
    arid = 16'h0038;
    araddr = 64'(8 * 64);
    arlen = 8'd0;
    arvalid = 1'b1;
    cyc(3);
    total_cnt++;
    if (arready !== 1'b0) $display("FAIL t3_stall arready=%b want 0", arready);
    else pass_cnt++;
    rready = 1'b1;
    got = 0;
    n = 0;
    while (got < 9 && n < 200) begin
      hs = arvalid && arready;
      if (rvalid) begin
        total_cnt++;
        if (rid !== 16'h0030 + 16'(got) || rdata !== pat(got + 100) ||
            rlast !== 1'b1)
          $display("FAIL t3_beat%0d id=%h data=%h last=%b want id %h",
                   got, rid, rdata[31:0], rlast, 16'h0030 + 16'(got));
        else pass_cnt++;
        if (got == 7) begin
          total_cnt++;
          if (n !== 7) $display("FAIL t3_nobubble cycle=%0d want 7", n);
          else pass_cnt++;
        end
        got++;
      end
      cyc(1);
      n++;
      if (hs) arvalid = 1'b0;
    end
    rready = 1'b0;
    arvalid = 1'b0;
    total_cnt++;
    if (got !== 9) $display("FAIL t3_count got %0d want 9", got);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    bd_write(4094, pat(4094));
    bd_write(4095, pat(4095));
    send_ar(16'h0044, 64'(4094 * 64), 8'd3);
    collect(4);
    total_cnt++;
    if (c_n !== 4) $display("FAIL t4_count got %0d want 4", c_n);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      total_cnt++;
      if (c_data[b] !== (b < 2 ? pat(4094 + b) : '0) ||
          c_resp[b] !== (b < 2 ? 2'b00 : 2'b10) ||
          c_last[b] !== (b == 3) || c_id[b] !== 16'h0044)
        $display("FAIL t4_beat%0d data=%h resp=%b last=%b id=%h",
                 b, c_data[b][31:0], c_resp[b], c_last[b], c_id[b]);
      else pass_cnt++;
    end
    for (int i = 62; i < 66; i++) bd_write(i, pat(i));
    send_ar(16'h0045, 64'(62 * 64), 8'd3);
    collect(4);
    total_cnt++;
    if (c_n !== 4) $display("FAIL t4_4k_count got %0d want 4", c_n);
    else pass_cnt++;
    for (int b = 0; b < 4; b++) begin
      total_cnt++;
      if (c_data[b] !== '0 || c_resp[b] !== 2'b10 ||
          c_last[b] !== (b == 3))
        $display("FAIL t4_4k_beat%0d data=%h resp=%b last=%b want 0 10",
                 b, c_data[b][31:0], c_resp[b], c_last[b]);
      else pass_cnt++;
    end
  endtask

  task automatic test_backdoor_rbw();
    int n;
    bd_write(20, pat(20));
    send_ar(16'h0050, 64'(20 * 64), 8'd0);
    cyc(3);
    bd_wr_en = 1'b1;
    bd_wr_addr = 12'd20;
    bd_wr_data = pat(99);
    cyc(1);
    bd_wr_en = 1'b0;
    total_cnt++;
    if (rvalid !== 1'b1 || rdata !== pat(20))
      $display("FAIL rbw_old rv=%b data=%h want 1 %h",
               rvalid, rdata[31:0], pat(20) >> 480);
    else pass_cnt++;
    collect(1);
    send_ar(16'h0051, 64'(20 * 64), 8'd0);
    wait_rvalid(n);
    total_cnt++;
    if (rdata !== pat(99))
      $display("FAIL rbw_new data=%h want %h", rdata[31:0], pat(99) >> 480);
    else pass_cnt++;
    collect(1);
  endtask

  task automatic test_cnt_wrap();
    int n;
    bd_write(9, pat(9));
    do_reset();
    cyc(65534);
    send_ar(16'h0066, 64'(9 * 64), 8'd0);
    wait_rvalid(n);
    total_cnt++;
    if (n !== 4) $display("FAIL t5_wrap_latency got %0d want 4", n);
    else pass_cnt++;
    total_cnt++;
    if (rdata !== pat(9) || rid !== 16'h0066)
      $display("FAIL t5_beat data=%h id=%h want %h 0066",
               rdata[31:0], rid, pat(9) >> 480);
    else pass_cnt++;
    collect(1);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int stale;
    send_ar(16'h0077, 64'h0, 8'd7);
    wait_rvalid(n);
    rready = 1'b1;
    cyc(2);
    rready = 1'b0;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (rvalid !== 1'b0 || arready !== 1'b0)
      $display("FAIL t6_rst rvalid=%b arready=%b want 0 0", rvalid, arready);
    else pass_cnt++;
    cyc(2);
    rst_n = 1'b1;
    rready = 1'b1;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) stale++;
      cyc(1);
    end
    rready = 1'b0;
    total_cnt++;
    if (stale !== 0) $display("FAIL t6_stale beats=%0d want 0", stale);
    else pass_cnt++;
    send_ar(16'h0078, 64'(9 * 64), 8'd0);
    wait_rvalid(n);
    total_cnt++;
    if (n !== 4 || rdata !== pat(9) || rid !== 16'h0078)
      $display("FAIL t6_after lat=%0d data=%h id=%h want 4 %h 0078",
               n, rdata[31:0], rid, pat(9) >> 480);
    else pass_cnt++;
    collect(1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall_burst();
    test_back_to_back();
    test_out_of_range();
    test_backdoor_rbw();
    test_cnt_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
